kbd_nibble_tx: RTL



---
 rtl/kbd_nibble_tx.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/kbd_nibble_tx.sv
// kbd_nibble_tx: byte FIFO feeding a nibble serialiser for the keyboard link.
// Each byte goes out as a high nibble framed by kbd_enb_hi, then a low nibble
// framed by kbd_enb_lo, followed by an idle gap before the next byte.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for a byte; pops the FIFO head when one is present
//   HI_SU  | high nibble on kbd_data, strobes low (setup)
//   HI_STB | kbd_enb_hi asserted, high nibble held
//   HI_HD  | one hold cycle, strobes low, high nibble still held
//   LO_SU  | low nibble on kbd_data, strobes low (setup)
//   LO_STB | kbd_enb_lo asserted, low nibble held
//   LO_HD  | one hold cycle, low nibble still held
//   GAP    | bus parked at 0 before the next byte may start
module kbd_nibble_tx #(
  parameter int SETUP_CYC  = 4,
  parameter int STROBE_CYC = 8,
  parameter int GAP_CYC    = 16,
  parameter int FIFO_AW    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level,
  output logic               overflow,
  output logic               busy,
  output logic               kbd_enb_hi,
  output logic               kbd_enb_lo,
  output logic [3:0]         kbd_data
);

  localparam int DEPTH = 1 << FIFO_AW;

  // Every timed state holds for (N) cycles by loading N-1 and leaving at zero.
  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] GAP_LD    = 8'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HI_SU  = 3'd1,
    HI_STB = 3'd2,
    HI_HD  = 3'd3,
    LO_SU  = 3'd4,
    LO_STB = 3'd5,
    LO_HD  = 3'd6,
    GAP    = 3'd7
  } state_t;

  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0]       lo_nib_q, lo_nib_d;
  logic [3:0]       data_q, data_d;
  logic             enb_hi_q, enb_hi_d;
  logic             enb_lo_q, enb_lo_d;

  logic             push;
  logic             pop;
  logic [7:0]       head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

  // full is judged before the same-cycle pop, so a write into a full FIFO is
  // dropped even when the serialiser frees a slot on that edge.
  assign push = wr_en && !full;
  assign pop  = (state_q == IDLE) && !empty;
  assign head = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  assign busy       = (state_q != IDLE);
  assign overflow   = overflow_q;
  assign kbd_enb_hi = enb_hi_q;
  assign kbd_enb_lo = enb_lo_q;
  assign kbd_data   = data_q;

  // FIFO pointer advance and dropped-write detection.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
    overflow_d = wr_en && full;
  end

  // FIFO storage; contents need no reset because occupancy lives in the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wr_data;
    end
  end

  // FIFO pointers and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Serialiser next state, down-counter and next values of the link outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    lo_nib_d = lo_nib_q;
    data_d   = data_q;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d  = HI_SU;
          cnt_d    = SETUP_LD;
          lo_nib_d = head[3:0];
          data_d   = head[7:4];
        end
      end
      HI_SU: begin
        if (cnt_q == 8'd0) begin
          state_d = HI_STB;
          cnt_d   = STROBE_LD;
        end
      end
      HI_STB: begin
        if (cnt_q == 8'd0) begin
          state_d = HI_HD;
          cnt_d   = 8'd0;
        end
      end
      HI_HD: begin
        if (cnt_q == 8'd0) begin
          state_d = LO_SU;
          cnt_d   = SETUP_LD;
          data_d  = lo_nib_q;
        end
      end
      LO_SU: begin
        if (cnt_q == 8'd0) begin
          state_d = LO_STB;
          cnt_d   = STROBE_LD;
        end
      end
      LO_STB: begin
        if (cnt_q == 8'd0) begin
          state_d = LO_HD;
          cnt_d   = 8'd0;
        end
      end
      LO_HD: begin
        if (cnt_q == 8'd0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
          data_d  = 4'h0;
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        data_d  = 4'h0;
      end
    endcase

    // Strobes follow the next state so they are registered with it.
    enb_hi_d = (state_d == HI_STB);
    enb_lo_d = (state_d == LO_STB);
  end

  // Serialiser state, counter and registered link outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      lo_nib_q <= 4'h0;
      data_q   <= 4'h0;
      enb_hi_q <= 1'b0;
      enb_lo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lo_nib_q <= lo_nib_d;
      data_q   <= data_d;
      enb_hi_q <= enb_hi_d;
      enb_lo_q <= enb_lo_d;
    end
  end

endmodule
